// File: rtl/ls7404_share_arbiter.sv
// ---------------------------------------------------------------------------
// ls7404_share_arbiter
//
// Round-robin arbiter and sequencer for one shared ls7404 hex-inverter bank.
// One requester is granted at a time. Its operand is registered onto the
// bank input. After SETTLE_CYCLES clocks the bank output is captured and
// returned to that requester with a one-cycle valid pulse.
//
// Parameters
//   N_REQ          number of requesters (2..8)
//   WIDTH          operand width, matches the ls7404 a/y width
//   SETTLE_CYCLES  clocks inv_a is held before inv_y is sampled (>=1)
//
// Ports
//   clk        in   1            system clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   req        in   N_REQ        request per user, held until its rsp_valid
//   req_data   in   N_REQ*WIDTH  operands, user i at [i*WIDTH +: WIDTH]
//   gnt        out  N_REQ        one-hot grant, high for the whole transaction
//   rsp_valid  out  N_REQ        one-cycle pulse to the granted user
//   rsp_data   out  WIDTH        captured inverter result, held until next capture
//   busy       out  1            high whenever the sequencer is not idle
//   inv_a      out  WIDTH        drive to the shared ls7404 .a input
//   inv_y      in   WIDTH        from the shared ls7404 .y output
//   grant_cnt  out  N_REQ*8      (ARB_GRANT_CNT_EN only) saturating per-user
//                                count of completed transactions
//
// Build option
//   ARB_GRANT_CNT_EN  when defined, adds the grant_cnt port and counters.
// ---------------------------------------------------------------------------
module ls7404_share_arbiter #(
  parameter int N_REQ         = 4,
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy,
  output logic [WIDTH-1:0]       inv_a,
  input  logic [WIDTH-1:0]       inv_y
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [N_REQ*8-1:0]     grant_cnt
`endif
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Next requester index, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] idx_incr(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] nxt;
    if (idx == IDX_W'(N_REQ - 1)) begin
      nxt = {IDX_W{1'b0}};
    end else begin
      nxt = idx + IDX_W'(1'b1);
    end
    return nxt;
  endfunction

  // First set request at or above start, wrapping around. The result is
  // only meaningful when at least one request bit is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick;
    logic             found;
    cand  = start;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && r[cand]) begin
        pick  = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
      cand = idx_incr(cand);
    end
    return pick;
  endfunction

  // One-hot code for a requester index.
  function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (idx == IDX_W'(i)) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // Operand slice belonging to requester idx.
  function automatic logic [WIDTH-1:0] operand_sel(input logic [N_REQ*WIDTH-1:0] data,
                                                   input logic [IDX_W-1:0]       idx);
    logic [WIDTH-1:0] d;
    d = {WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (idx == IDX_W'(i)) begin
        d = data[i*WIDTH +: WIDTH];
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // -------------------------------------------------------------------------
  // State and next-state signals
  // -------------------------------------------------------------------------
  state_t           state_r;
  state_t           state_next_s;
  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] rr_ptr_next_s;
  logic [IDX_W-1:0] winner_r;
  logic [IDX_W-1:0] winner_next_s;
  logic [CNT_W-1:0] settle_cnt_r;
  logic [CNT_W-1:0] settle_cnt_next_s;
  logic [N_REQ-1:0] gnt_r;
  logic [N_REQ-1:0] gnt_next_s;
  logic [N_REQ-1:0] rsp_valid_r;
  logic [N_REQ-1:0] rsp_valid_next_s;
  logic [WIDTH-1:0] rsp_data_r;
  logic [WIDTH-1:0] rsp_data_next_s;
  logic [WIDTH-1:0] inv_a_r;
  logic [WIDTH-1:0] inv_a_next_s;
  logic             busy_r;
  logic             busy_next_s;

  logic [IDX_W-1:0] pick_s;
  logic [WIDTH-1:0] operand_s;

  assign pick_s    = rr_pick(req, rr_ptr_r);
  assign operand_s = operand_sel(req_data, pick_s);

  // Next-state and next-output decode for the IDLE -> SETTLE -> DONE sequence.
  always_comb begin
    state_next_s      = state_r;
    rr_ptr_next_s     = rr_ptr_r;
    winner_next_s     = winner_r;
    settle_cnt_next_s = settle_cnt_r;
    gnt_next_s        = gnt_r;
    rsp_valid_next_s  = {N_REQ{1'b0}};
    rsp_data_next_s   = rsp_data_r;
    inv_a_next_s      = inv_a_r;

    case (state_r)
      ST_IDLE: begin
        if (req != {N_REQ{1'b0}}) begin
          winner_next_s     = pick_s;
          inv_a_next_s      = operand_s;
          gnt_next_s        = idx_onehot(pick_s);
          settle_cnt_next_s = CNT_W'(SETTLE_CYCLES);
          state_next_s      = ST_SETTLE;
        end else begin
          gnt_next_s = {N_REQ{1'b0}};
        end
      end

      ST_SETTLE: begin
        settle_cnt_next_s = settle_cnt_r - CNT_W'(1'b1);
        // Sampling on the last settle cycle makes the pulse land in DONE.
        if (settle_cnt_r == CNT_W'(1'b1)) begin
          rsp_data_next_s  = inv_y;
          rsp_valid_next_s = idx_onehot(winner_r);
          state_next_s     = ST_DONE;
        end else begin
          state_next_s = ST_SETTLE;
        end
      end

      ST_DONE: begin
        // No arbitration here. The next grant is decided in IDLE from the
        // advanced pointer.
        rr_ptr_next_s = idx_incr(winner_r);
        gnt_next_s    = {N_REQ{1'b0}};
        state_next_s  = ST_IDLE;
      end

      default: begin
        gnt_next_s        = {N_REQ{1'b0}};
        settle_cnt_next_s = {CNT_W{1'b0}};
        state_next_s      = ST_IDLE;
      end
    endcase

    busy_next_s = (state_next_s != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r     <= {IDX_W{1'b0}};
      winner_r     <= {IDX_W{1'b0}};
      settle_cnt_r <= {CNT_W{1'b0}};
      gnt_r        <= {N_REQ{1'b0}};
      rsp_valid_r  <= {N_REQ{1'b0}};
      rsp_data_r   <= {WIDTH{1'b0}};
      inv_a_r      <= {WIDTH{1'b0}};
      busy_r       <= 1'b0;
    end else begin
      rr_ptr_r     <= rr_ptr_next_s;
      winner_r     <= winner_next_s;
      settle_cnt_r <= settle_cnt_next_s;
      gnt_r        <= gnt_next_s;
      rsp_valid_r  <= rsp_valid_next_s;
      rsp_data_r   <= rsp_data_next_s;
      inv_a_r      <= inv_a_next_s;
      busy_r       <= busy_next_s;
    end
  end

  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_r;
  assign inv_a     = inv_a_r;

`ifdef ARB_GRANT_CNT_EN
  // -------------------------------------------------------------------------
  // Per-requester saturating grant counters
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < N_REQ; g++) begin : g_grant_cnt
    logic [7:0] cnt_r;

    // Count each completed transaction for this requester, stopping at 8'hFF.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= 8'h00;
      end else if ((state_r == ST_DONE) && (winner_r == IDX_W'(g)) && (cnt_r != 8'hFF)) begin
        cnt_r <= cnt_r + 8'h01;
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign grant_cnt[g*8 +: 8] = cnt_r;
  end
`endif

endmodule

// File: tb/tb_ls7404_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ls7404_share_arbiter
//
// Directed bench for ls7404_share_arbiter with default parameters. The
// ls7404 bank is modelled inline as a combinational inverter (y = ~a).
// The stimulus pushes the expected response (requester, data, cycle) into a
// queue. A negedge monitor pops and compares whenever rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_ls7404_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [23:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [5:0]  rsp_data;
  logic        busy;
  logic [5:0]  inv_a;
  logic [5:0]  inv_y;
`ifdef ARB_GRANT_CNT_EN
  logic [31:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  // ls7404 hex inverter bank.
  assign inv_y = ~inv_a;

  ls7404_share_arbiter #(
    .N_REQ        (4),
    .WIDTH        (6),
    .SETTLE_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .inv_a    (inv_a),
    .inv_y    (inv_y)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt(grant_cnt)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [5:0] data;
    int         at;
  } want_t;

  want_t want_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, want, cyc);
  endtask

  task automatic push_want(input int idx, input logic [5:0] d, input int at);
    want_t w;
    w.idx  = idx;
    w.data = d;
    w.at   = at;
    want_q.push_back(w);
  endtask

  task automatic set_data(input int i, input logic [5:0] d);
    req_data[i*6 +: 6] = d;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((want_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {31'd0, (want_q.size() == 0 && busy === 1'b0)}, 32'd1);
  endtask

  // Response monitor: every rsp_valid pulse must match the head of the queue.
  always @(negedge clk) begin : mon
    want_t      w;
    logic [3:0] oh;
    if (rst_n === 1'b1 && rsp_valid !== 4'b0000) begin
      if (want_q.size() == 0) begin
        chk("unexpected_rsp", {28'd0, rsp_valid}, 32'd0);
      end else begin
        w  = want_q.pop_front();
        oh = 4'b0001 << w.idx;
        chk("rsp_valid", {28'd0, rsp_valid}, {28'd0, oh});
        chk("rsp_data", {26'd0, rsp_data}, {26'd0, w.data});
        chk("rsp_cycle", cyc, w.at);
        chk("gnt_in_done", {28'd0, gnt}, {28'd0, oh});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d responses outstanding", want_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst_n    = 1'b0;
    req      = 4'b0000;
    req_data = 24'd0;
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {26'd0, rsp_data}, 32'd0);
    chk("rst_inv_a", {26'd0, inv_a}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from user 1; operand change mid-transaction is ignored.
    set_data(1, 6'b001010);
    req = 4'b0010;
    e   = cyc + 1;
    push_want(1, 6'b110101, e + 2);
    @(posedge clk);
    #1;
    chk("t2_gnt", {28'd0, gnt}, 32'h2);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    chk("t2_inv_a", {26'd0, inv_a}, {26'd0, 6'b001010});
    chk("t2_no_rsp_at_grant", {28'd0, rsp_valid}, 32'd0);
    set_data(1, 6'b111000);
    wait_cyc(e + 1);
    chk("t2_no_rsp_early", {28'd0, rsp_valid}, 32'd0);
    wait_cyc(e + 2);
    req = 4'b0000;
    wait_cyc(e + 3);
    chk("t2_rsp_one_cycle", {28'd0, rsp_valid}, 32'd0);
    chk("t2_gnt_clear", {28'd0, gnt}, 32'd0);
    chk("t2_idle", {31'd0, busy}, 32'd0);
    chk("t2_rsp_hold", {26'd0, rsp_data}, {26'd0, 6'b110101});
    chk("t2_inv_a_hold", {26'd0, inv_a}, {26'd0, 6'b001010});
    drain(20);

    // All four requesting from reset: order 0,1,2,3,0, four cycles apart.
    do_reset();
    set_data(0, 6'b000001);
    set_data(1, 6'b010011);
    set_data(2, 6'b100110);
    set_data(3, 6'b111100);
    req = 4'b1111;
    e   = cyc + 1;
    push_want(0, 6'b111110, e + 2);
    push_want(1, 6'b101100, e + 6);
    push_want(2, 6'b011001, e + 10);
    push_want(3, 6'b000011, e + 14);
    push_want(0, 6'b111110, e + 18);
    wait_cyc(e + 18);
    req = 4'b0000;
    drain(30);

    // Users 0 and 3 held; user 1 joins later and is served within 2 turns.
    do_reset();
    set_data(0, 6'b101010);
    set_data(3, 6'b000111);
    set_data(1, 6'b110011);
    req = 4'b1001;
    e   = cyc + 1;
    push_want(0, 6'b010101, e + 2);
    push_want(3, 6'b111000, e + 6);
    push_want(0, 6'b010101, e + 10);
    push_want(1, 6'b001100, e + 14);
    push_want(3, 6'b111000, e + 18);
    push_want(0, 6'b010101, e + 22);
    wait_cyc(e + 9);
    req[1] = 1'b1;
    wait_cyc(e + 14);
    req[1] = 1'b0;
    wait_cyc(e + 22);
    req = 4'b0000;
    drain(30);

    // Request dropped one cycle after grant still completes.
    set_data(2, 6'b011110);
    req = 4'b0100;
    e   = cyc + 1;
    push_want(2, 6'b100001, e + 2);
    @(posedge clk);
    #1;
    chk("t5_gnt", {28'd0, gnt}, 32'h4);
    wait_cyc(e + 1);
    req = 4'b0000;
    drain(20);

    // Reset during SETTLE: outputs clear at once, no response emitted.
    set_data(0, 6'b001100);
    req = 4'b0001;
    e   = cyc + 1;
    @(posedge clk);
    #1;
    chk("t5b_gnt", {28'd0, gnt}, 32'h1);
    wait_cyc(e + 1);
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    chk("async_gnt", {28'd0, gnt}, 32'd0);
    chk("async_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("async_rsp_data", {26'd0, rsp_data}, 32'd0);
    chk("async_inv_a", {26'd0, inv_a}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Pointer back at 0: user 0 wins before user 3.
    set_data(0, 6'b110000);
    set_data(3, 6'b010010);
    req = 4'b1001;
    e   = cyc + 1;
    push_want(0, 6'b001111, e + 2);
    push_want(3, 6'b101101, e + 6);
    wait_cyc(e + 2);
    req[0] = 1'b0;
    wait_cyc(e + 6);
    req = 4'b0000;
    drain(20);

`ifdef ARB_GRANT_CNT_EN
    // 300 back-to-back transactions for user 1 saturate its counter only.
    do_reset();
    chk("cnt_reset", grant_cnt, 32'd0);
    set_data(1, 6'b100100);
    req = 4'b0010;
    e   = cyc + 1;
    for (int k = 0; k < 300; k++) push_want(1, 6'b011011, e + 2 + 4 * k);
    wait_cyc(e + 2 + 4 * 299);
    req = 4'b0000;
    drain(40);
    chk("cnt_saturate", grant_cnt, 32'h0000FF00);
`endif

    chk("queue_empty", want_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
